// File: rtl/trace_cmd_queue.sv
// Trace command front-end: filters illegal command codes, buffers legal records in a
// small FIFO and presents the head record split into tag/index/offset for the controller.
module trace_cmd_queue #(
    parameter int DEPTH    = 4,
    parameter int ADDR_W   = 32,
    parameter int INDEX_W  = 14,
    parameter int OFFSET_W = 6,
    localparam int TAG_W   = ADDR_W - INDEX_W - OFFSET_W
) (
    input  logic                       clk,
    input  logic                       clear,
    input  logic                       in_valid,
    input  logic [3:0]                 n,
    input  logic [ADDR_W-1:0]          add_in,
    output logic                       in_ready,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [3:0]                 out_cmd,
    output logic [TAG_W-1:0]           out_tag,
    output logic [INDEX_W-1:0]         out_index,
    output logic [OFFSET_W-1:0]        out_offset,
    output logic [TAG_W+INDEX_W-1:0]   out_line_addr,
    output logic [31:0]                accept_cnt,
    output logic [15:0]                drop_cnt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [3:0]        r_mem_cmd  [DEPTH];
    logic [ADDR_W-1:0] r_mem_addr [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic [31:0]       r_accept_cnt;
    logic [15:0]       r_drop_cnt;

    logic              w_legal;
    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic              w_pop;
    logic [3:0]        w_head_cmd;
    logic [ADDR_W-1:0] w_head_addr;

    always_comb begin
        w_legal = (n <= 4'd6) || (n == 4'd8) || (n == 4'd9);
        w_full  = (r_count == FULL_CNT);
        w_empty = (r_count == '0);
        // A full queue never takes a new record, even when the head pops this cycle.
        w_push  = in_valid && w_legal && !w_full;
        w_pop   = !w_empty && out_ready;
    end

    // NOTE: storage carries no reset; the pointers and count define which entries are live.
    always_ff @(posedge clk) begin
        if (!clear && w_push) begin
            r_mem_cmd[r_wr_ptr]  <= n;
            r_mem_addr[r_wr_ptr] <= add_in;
        end
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_accept_cnt <= '0;
            r_drop_cnt   <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr     <= r_wr_ptr + PTR_W'(1);
                r_accept_cnt <= r_accept_cnt + 32'd1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
            // Illegal codes are discarded whether or not the queue has room.
            if (in_valid && !w_legal && (r_drop_cnt != 16'hFFFF)) begin
                r_drop_cnt <= r_drop_cnt + 16'd1;
            end
        end
    end

    always_comb begin
        w_head_cmd  = 4'd0;
        w_head_addr = '0;
        if (!w_empty) begin
            w_head_cmd  = r_mem_cmd[r_rd_ptr];
            w_head_addr = r_mem_addr[r_rd_ptr];
        end
    end

    assign in_ready      = !w_full;
    assign out_valid     = !w_empty;
    assign out_cmd       = w_head_cmd;
    assign out_tag       = w_head_addr[ADDR_W-1 -: TAG_W];
    assign out_index     = w_head_addr[OFFSET_W +: INDEX_W];
    assign out_offset    = w_head_addr[OFFSET_W-1:0];
    assign out_line_addr = {out_tag, out_index};
    assign accept_cnt    = r_accept_cnt;
    assign drop_cnt      = r_drop_cnt;

endmodule
